vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- VGA timing generator directly downstream of the pixel-clock divider.
- Consumes the divider's square-wave output, detects its rising edge as a one-cycle pixel tick, and runs horizontal/vertical counters.
- Produces hsync, vsync, video_on, pixel coordinates and a frame-start pulse for the pixel/colour stages.
- Defaults are 640x480@60 with a 25 MHz tick from a 100 MHz clk_in.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BACK, 48, horizontal back porch (ticks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync during the sync pulse (0 = active-low)

Ports:
- clk_in  input  1  system clock (100 MHz)
- reset  input  1  synchronous, active-high reset
- pix_clk_in  input  1  divided pixel clock from the divider (square wave, sampled on clk_in)
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  output  10  current horizontal count
- pixel_y  output  10  current vertical count
- frame_start  output  1  one-clk_in pulse when counters wrap to (0,0)
- rgb_out  output  12  4:4:4 colour; test pattern or zero, see Optional Feature

Behaviour:
- Clock and reset: one clock, clk_in. reset is synchronous and active-high; all state changes only on posedge clk_in.
- Tick detection:
  - pix_prev <= pix_clk_in every clk_in cycle.
  - tick = pix_clk_in & ~pix_prev, combinational.
  - A level held high produces exactly one tick.
- Counter ranges: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Both must be ≤ 1024; this is not checked in RTL.
- Counter update on the clock edge where tick=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - With tick=0, all counters and outputs hold.
- Output registration:
  - All outputs are registered and decoded from the next-state counts, so in any cycle hsync/vsync/video_on/rgb_out correspond exactly to the pixel_x/pixel_y shown that cycle.
  - Latency from the sampled pix_clk_in rising edge to the new pixel_x is one clk_in edge.
- Decodes (default values in brackets):
  - hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT ≤ x ≤ H_DISPLAY+H_FRONT+H_SYNC-1 [656..751], else ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_DISPLAY+V_FRONT ≤ y ≤ V_DISPLAY+V_FRONT+V_SYNC-1 [490..491], else ~SYNC_ACTIVE.
  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
- frame_start:
  - High for exactly one clk_in cycle, the cycle in which pixel_x/pixel_y first read (0,0) after wrapping from (799,524).
  - Not asserted on reset release.
- Reset values:
  - pix_prev=0, pixel_x=0, pixel_y=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - video_on=1, frame_start=0, rgb_out=0.
- Reset mid-line or mid-frame: all of the above is restored on the next edge. The first tick after release advances to (1,0).
- Simultaneous reset and tick: reset wins and the tick is discarded.
- If pix_clk_in is stuck at 0 or 1, counters hold indefinitely. No timeout.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - rgb_out shows 8 vertical colour bars, each H_DISPLAY/8 = 80 pixels wide.
  - bar index = pixel_x[9:0] / 80 (use a comparator chain, no divider).
  - Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - rgb_out = 000 whenever video_on=0.
  - Registered with the same alignment as video_on.
- Undefined: rgb_out is constant 12'h000 and no pattern logic is synthesised.

Test Plan:
- Reset: reset=1 for 3 clocks, pix_clk_in toggling -> pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=1, frame_start=0 throughout.
- Tick rate: pix_clk_in pattern 0,0,1,1 repeating -> pixel_x advances by exactly 1 every 4 clk_in. Holding pix_clk_in=1 for 20 clocks yields exactly one increment.
- Hsync window: run one line -> hsync=0 exactly for pixel_x 656..751 (96 ticks). video_on falls when pixel_x goes 639->640. Line wraps 799->0 with pixel_y +1.
- Frame: run a full frame -> vsync=0 for pixel_y 490..491 (1600 ticks). frame_start pulses once, 1 clk wide, at (0,0) after (799,524). Total = 420000 ticks.
- Mid-frame reset: assert reset at (300,200) simultaneous with a tick -> next cycle shows (0,0). The first tick after release gives (1,0). No frame_start.
- VGA_TEST_PATTERN_EN defined: rgb_out=FFF at x=0, FF0 at x=80, 000 at x=639, and 000 at x=700 (blank); undefined: rgb_out=000 everywhere.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: turns the divided pixel clock into a one-cycle tick and
// runs horizontal/vertical counters, producing registered sync, blanking,
// coordinates and a frame-start pulse.
// Optional macro VGA_TEST_PATTERN_EN: drives eight vertical colour bars on
// rgb_out. When it is undefined, rgb_out is tied to zero.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_clk_in,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [11:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       pix_prev;
  logic       tick;
  logic       h_last;
  logic       v_last;
  logic       wrap;
  logic [9:0] x_d;
  logic [9:0] y_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       video_on_d;

  assign tick = pix_clk_in & ~pix_prev;

  // Next-state counts and their decodes; outputs register these so every
  // output lines up with the coordinates shown in the same cycle.
  always_comb begin
    h_last = (pixel_x == H_LAST);
    v_last = (pixel_y == V_LAST);
    wrap   = h_last & v_last;
    x_d    = h_last ? 10'd0 : pixel_x + 10'd1;
    y_d    = pixel_y;
    if (h_last) begin
      y_d = v_last ? 10'd0 : pixel_y + 10'd1;
    end
    hsync_d    = ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  // Edge detector, counters and registered timing outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pix_prev    <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_prev    <= pix_clk_in;
      // Pulse lasts one clk_in cycle even though other outputs hold per tick.
      frame_start <= tick & wrap;
      if (tick) begin
        pixel_x  <= x_d;
        pixel_y  <= y_d;
        hsync    <= hsync_d;
        vsync    <= vsync_d;
        video_on <= video_on_d;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_DISPLAY / 8;

  logic [2:0]  bar_idx;
  logic [11:0] bar_rgb;
  logic [11:0] rgb_d;

  // Bar index via a comparator chain; descending loop leaves the lowest match.
  always_comb begin
    bar_idx = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if (x_d < 10'(BAR_W * (k + 1))) begin
        bar_idx = 3'(k);
      end
    end
    unique case (bar_idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
    rgb_d = video_on_d ? bar_rgb : 12'h000;
  end

  // Colour register, aligned with video_on.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rgb_out <= 12'h000;
    end else if (tick) begin
      rgb_out <= rgb_d;
    end
  end
`else
  assign rgb_out = 12'h000;
`endif

endmodule
